// File: rtl/scan_unload_checker_if.sv
// ---------------------------------------------------------------------------
// scan_unload_checker_if
// Signals between the scan unload checker, the pattern source that supplies
// the expected/mask stream, and the scan chain under test.
//
//   start          pattern source -> checker : request one capture+unload run
//   exp_valid      pattern source -> checker : exp_bit/exp_mask valid
//   exp_bit        pattern source -> checker : expected scan-out value
//   exp_mask       pattern source -> checker : 1 = don't-care bit
//   so             chain          -> checker : scan-out of the last flop
//   exp_ready      checker -> pattern source : expected bit accepted this cycle
//   se             checker -> chain          : scan enable (0 = capture)
//   chain_ce       checker -> chain          : chain clock enable
//   busy, done     checker status
//   fail, err_cnt, first_err_idx  results of the last run
// ---------------------------------------------------------------------------
interface scan_unload_checker_if #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 5
) ();
    logic             start;
    logic             exp_valid;
    logic             exp_bit;
    logic             exp_mask;
    logic             so;
    logic             exp_ready;
    logic             se;
    logic             chain_ce;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [IDX_W-1:0] first_err_idx;

    // Pattern source / chain side
    modport master (
        output start, exp_valid, exp_bit, exp_mask, so,
        input  exp_ready, se, chain_ce, busy, done, fail, err_cnt, first_err_idx
    );

    // Checker side
    modport slave (
        input  start, exp_valid, exp_bit, exp_mask, so,
        output exp_ready, se, chain_ce, busy, done, fail, err_cnt, first_err_idx
    );
endinterface

// File: rtl/scan_unload_checker.sv
// ---------------------------------------------------------------------------
// scan_unload_checker
// Drives one scan chain of CHAIN_LEN flops through a functional capture and a
// serial unload, comparing every unloaded bit against an expected/mask stream.
// Reports pass/fail, a saturating mismatch count and the first failing index.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   scan_unload_checker_if.slave (handshake, chain control, results)
//
// Bit index 0 is the value on so before the first shift.
// ---------------------------------------------------------------------------
module scan_unload_checker #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 5
) (
    input logic                  clk,
    input logic                  rst,
    scan_unload_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] NO_ERR   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             fail_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [IDX_W-1:0] first_err_idx_q;
    logic             hs;
    logic             mism;

    // Counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Same condition as exp_valid & exp_ready, written from the state so the
    // decode below has no loop through exp_ready.
    assign hs   = bus.exp_valid && (state == SHIFT);
    assign mism = hs && !bus.exp_mask && (bus.so ^ bus.exp_bit);

    always_comb begin
        state_nxt     = state;
        bus.exp_ready = 1'b0;
        bus.se        = 1'b0;
        bus.chain_ce  = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                bus.chain_ce = 1'b1;
                state_nxt    = SHIFT;
            end
            SHIFT: begin
                bus.se        = 1'b1;
                bus.exp_ready = 1'b1;
                // The chain only advances when a compare actually happens.
                bus.chain_ce  = bus.exp_valid;
                if (bus.exp_valid && (idx == LAST_IDX)) state_nxt = FINISH;
            end
            FINISH: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            fail_q          <= 1'b0;
            err_cnt_q       <= '0;
            first_err_idx_q <= NO_ERR;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.start) begin
                idx             <= '0;
                fail_q          <= 1'b0;
                err_cnt_q       <= '0;
                first_err_idx_q <= NO_ERR;
            end else if (hs) begin
                idx <= idx + IDX_W'(1);
                if (mism) begin
                    fail_q    <= 1'b1;
                    err_cnt_q <= sat_inc(err_cnt_q);
                    // fail_q still low means this is the run's first mismatch.
                    if (!fail_q) first_err_idx_q <= idx;
                end
            end
        end
    end

    assign bus.fail          = fail_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_scan_unload_checker.sv
// ---------------------------------------------------------------------------
// tb_scan_unload_checker
// Two checkers (CNT_W=8 and CNT_W=2) run side by side on identical stimulus,
// each unloading its own behavioural scan chain. A run-level model derives
// control outputs and results from the number of bits accepted so far.
// ---------------------------------------------------------------------------
module tb_scan_unload_checker;
    localparam int L     = 16;
    localparam int IDX_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus
    logic         start;
    logic         exp_valid;
    logic [L-1:0] cur_r, cur_e, cur_m;

    // Run-level model
    logic [L-1:0] m_r = '0, m_e = '0, m_m = '0;
    bit           m_active = 0, m_cap = 0, m_done = 0;
    int           m_taken = 0;

    logic [L-1:0] chain0 = '0, chain1 = '0;
    int  n_tests = 0, n_fail = 0;
    int  ce_cnt = 0, done_cnt = 0;
    bit  chk_en = 0;

    scan_unload_checker_if #(.CNT_W(8), .IDX_W(IDX_W)) if0 ();
    scan_unload_checker_if #(.CNT_W(2), .IDX_W(IDX_W)) if1 ();

    scan_unload_checker #(.CHAIN_LEN(L), .CNT_W(8), .IDX_W(IDX_W)) dut0 (
        .clk(clk), .rst(rst), .bus(if0));
    scan_unload_checker #(.CHAIN_LEN(L), .CNT_W(2), .IDX_W(IDX_W)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));

    // Pattern source: presents the expected bit for the next unaccepted index.
    assign if0.start     = start;
    assign if1.start     = start;
    assign if0.exp_valid = exp_valid;
    assign if1.exp_valid = exp_valid;
    assign if0.exp_bit   = m_e[m_taken[3:0]];
    assign if1.exp_bit   = m_e[m_taken[3:0]];
    assign if0.exp_mask  = m_m[m_taken[3:0]];
    assign if1.exp_mask  = m_m[m_taken[3:0]];
    assign if0.so        = chain0[0];
    assign if1.so        = chain1[0];

    // Scan chains: capture the run's response with se=0, shift toward so with se=1.
    always @(posedge clk) begin
        if (if0.chain_ce) chain0 <= if0.se ? (chain0 >> 1) : m_r;
        if (if1.chain_ce) chain1 <= if1.se ? (chain1 >> 1) : m_r;
    end

    // A run: one capture cycle, CHAIN_LEN accepted bits, one done cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 0; m_cap <= 0; m_done <= 0; m_taken <= 0;
        end else begin
            m_done <= 0;
            if (!m_active && !m_done) begin
                if (start) begin
                    m_active <= 1; m_cap <= 1; m_taken <= 0;
                    m_r <= cur_r; m_e <= cur_e; m_m <= cur_m;
                end
            end else if (m_cap) begin
                m_cap <= 0;
            end else if (m_active && exp_valid) begin
                m_taken <= m_taken + 1;
                if (m_taken == L - 1) begin
                    m_active <= 0; m_done <= 1;
                end
            end
        end
    end

    function automatic bit bit_mism(input int i);
        return !m_m[i] && (m_r[i] != m_e[i]);
    endfunction

    function automatic int exp_cnt(input int w);
        int c = 0;
        for (int i = 0; i < L; i++) if (i < m_taken && bit_mism(i)) c++;
        return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
    endfunction

    function automatic int exp_first();
        int f = (1 << IDX_W) - 1;
        for (int i = L - 1; i >= 0; i--) if (i < m_taken && bit_mism(i)) f = i;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        bit e_se, e_ce, e_busy;
        if (chk_en) begin
            e_se   = m_active && !m_cap;
            e_ce   = m_cap || (e_se && exp_valid);
            e_busy = m_active || m_done;
            if (if0.chain_ce) ce_cnt++;
            if (if0.done) done_cnt++;
            chk("d0.busy", 32'(if0.busy), 32'(e_busy));
            chk("d0.se", 32'(if0.se), 32'(e_se));
            chk("d0.exp_ready", 32'(if0.exp_ready), 32'(e_se));
            chk("d0.chain_ce", 32'(if0.chain_ce), 32'(e_ce));
            chk("d0.done", 32'(if0.done), 32'(m_done));
            chk("d0.fail", 32'(if0.fail), 32'(exp_cnt(8) != 0));
            chk("d0.err_cnt", 32'(if0.err_cnt), 32'(exp_cnt(8)));
            chk("d0.first_err_idx", 32'(if0.first_err_idx), 32'(exp_first()));
            chk("d1.busy", 32'(if1.busy), 32'(e_busy));
            chk("d1.se", 32'(if1.se), 32'(e_se));
            chk("d1.chain_ce", 32'(if1.chain_ce), 32'(e_ce));
            chk("d1.done", 32'(if1.done), 32'(m_done));
            chk("d1.fail", 32'(if1.fail), 32'(exp_cnt(2) != 0));
            chk("d1.err_cnt", 32'(if1.err_cnt), 32'(exp_cnt(2)));
            chk("d1.first_err_idx", 32'(if1.first_err_idx), 32'(exp_first()));
        end
    end

    // One run with hand-computed literal results; optional 3-cycle stall after
    // bit 5 and an ignored start pulse during SHIFT.
    task automatic run(input string tag, input logic [L-1:0] r, input logic [L-1:0] e,
                       input logic [L-1:0] m, input bit stall, input bit mid_start,
                       input int lat, input int fl, input int c0, input int c1, input int first);
        int  edges = 0;
        int  stall_left;
        bit  got = 0;
        bit  pulsed = 0;
        cur_r = r; cur_e = e; cur_m = m;
        ce_cnt = 0; done_cnt = 0;
        stall_left = stall ? 3 : 0;
        exp_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (edges < 100) begin
            @(negedge clk);
            if (if0.done) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            edges++;
            exp_valid = 1'b1;
            if (stall_left > 0 && m_taken == 6) begin
                exp_valid = 1'b0;
                stall_left--;
            end
            start = mid_start && !pulsed && (m_taken == 4);
            if (start) pulsed = 1;
        end
        if (!got) chk({tag, ".timeout"}, 32'd0, 32'd1);
        chk({tag, ".latency"}, 32'(edges), 32'(lat));
        chk({tag, ".fail"}, 32'(if0.fail), 32'(fl));
        chk({tag, ".err_cnt8"}, 32'(if0.err_cnt), 32'(c0));
        chk({tag, ".err_cnt2"}, 32'(if1.err_cnt), 32'(c1));
        chk({tag, ".first_err_idx"}, 32'(if0.first_err_idx), 32'(first));
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, ".chain_ce_pulses"}, 32'(ce_cnt), 32'(L + 1));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; exp_valid = 1'b1;
        cur_r = '0; cur_e = '0; cur_m = '0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("reset.busy", 32'(if0.busy), 32'd0);
        chk("reset.err_cnt", 32'(if0.err_cnt), 32'd0);
        chk("reset.first_err_idx", 32'(if0.first_err_idx), 32'd31);
        @(posedge clk); #1 rst = 1'b0;

        // Clean unload: results all-pass, done CHAIN_LEN+1 edges after the start edge.
        run("clean", 16'hA5C3, 16'hA5C3, 16'h0000, 0, 0, 17, 0, 0, 0, 31);
        // Mismatches at bits 3 and 10.
        run("two_err", 16'hA5C3, 16'hA1CB, 16'h0000, 0, 0, 17, 1, 2, 2, 3);
        // Bit 3 masked.
        run("mask3", 16'hA5C3, 16'hA1CB, 16'h0008, 0, 0, 17, 1, 1, 1, 10);
        // Fully masked run with every bit wrong.
        run("all_mask", 16'hA5C3, 16'h5A3C, 16'hFFFF, 0, 0, 17, 0, 0, 0, 31);
        // Stall of 3 cycles after bit 5: same results, 3 cycles later.
        run("stall", 16'hA5C3, 16'hA1CB, 16'h0000, 1, 0, 20, 1, 2, 2, 3);
        // Every bit wrong: 8-bit counter reaches 16, 2-bit counter saturates at 3.
        run("sat", 16'hA5C3, 16'h5A3C, 16'h0000, 0, 1, 17, 1, 16, 3, 0);

        // Reset mid-run at idx 7 discards partial results.
        cur_r = 16'hA5C3; cur_e = 16'h5A3C; cur_m = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 50 && m_taken != 7; k++) begin @(posedge clk); #1; end
        chk("midrst.reached_idx7", 32'(m_taken), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.partial_err_cnt", 32'(if0.err_cnt), 32'd7);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst.busy", 32'(if0.busy), 32'd0);
        chk("midrst.se", 32'(if0.se), 32'd0);
        chk("midrst.err_cnt", 32'(if0.err_cnt), 32'd0);
        chk("midrst.fail", 32'(if0.fail), 32'd0);
        chk("midrst.first_err_idx", 32'(if0.first_err_idx), 32'd31);
        @(posedge clk); #1;
        run("after_rst", 16'hA5C3, 16'hA5C3, 16'h0000, 0, 0, 17, 0, 0, 0, 31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
